// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_pkg;

    // Opcodes that read rt as a source operand
    localparam logic [5:0] OpRType = 6'd0;
    localparam logic [5:0] OpBeq   = 6'd4;
    localparam logic [5:0] OpBne   = 6'd5;
    localparam logic [5:0] OpSw    = 6'd43;

    // Instruction field bit positions
    localparam int unsigned OpcodeMsb = 31;
    localparam int unsigned OpcodeLsb = 26;
    localparam int unsigned RsMsb     = 25;
    localparam int unsigned RsLsb     = 21;
    localparam int unsigned RtMsb     = 20;
    localparam int unsigned RtLsb     = 16;

    // Freeze length after which the memory is declared timed out
    localparam logic [7:0] FreezeLimit = 8'd255;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StFreeze  = 2'd1,
        StTimeout = 2'd2
    } hz_state_e;

    // True when the instruction in ID reads rt as a source register
    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OpRType) || (opcode == OpBeq) ||
               (opcode == OpBne) || (opcode == OpSw);
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones; synchronous clear wins over count.
module sat_counter16 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        clr_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q, count_d;

    // Next count: clear, else saturating increment
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, branch flush, load-use stall,
// plus stall/flush performance counters and a sticky memory timeout flag.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_ID,
    input  logic [31:0] instruction_EX,
    input  logic        MemRead_EX,
    input  logic        BranchEQ_EX,
    input  logic        BranchNE_EX,
    input  logic        Jump_EX,
    input  logic        Zero_EX,
    input  logic        mem_busy,
    input  logic        clear_counters,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        ID_EX_Write,
    output logic        EX_MEM_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Bubble,
    output logic        PC_Src_Taken,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic        mem_timeout,
    output logic [1:0]  state
);

    logic [5:0] opcode_id;
    logic [4:0] rs_id, rt_id, rt_ex;
    logic       taken, load_use;
    logic       stall_en, flush_en;

    hz_state_e  state_q, state_d;
    logic [7:0] frz_cnt_q, frz_cnt_d;
    logic       timeout_q, timeout_d;

    // Only the register fields matter here; the rest is deliberately ignored
    logic unused_fields;
    assign unused_fields = ^{instruction_ID[15:0], instruction_EX[31:21], instruction_EX[15:0]};

    assign opcode_id = instruction_ID[OpcodeMsb:OpcodeLsb];
    assign rs_id     = instruction_ID[RsMsb:RsLsb];
    assign rt_id     = instruction_ID[RtMsb:RtLsb];
    assign rt_ex     = instruction_EX[RtMsb:RtLsb];

    assign taken    = (BranchEQ_EX & Zero_EX) | (BranchNE_EX & ~Zero_EX) | Jump_EX;
    assign load_use = MemRead_EX & (rt_ex != 5'd0) &
                      ((rt_ex == rs_id) | (uses_rt(opcode_id) & (rt_ex == rt_id)));

    // Priority-ordered pipeline control: freeze, then redirect, then load-use stall
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        PC_Src_Taken = 1'b0;
        stall_en     = 1'b0;
        flush_en     = 1'b0;
        if (mem_busy) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            stall_en     = 1'b1;
        end else if (taken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            PC_Src_Taken = 1'b1;
            flush_en     = 1'b1;
        end else if (load_use) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            stall_en     = 1'b1;
        end
    end

    // Freeze FSM next state, freeze-length counter and sticky timeout flag
    always_comb begin
        state_d   = state_q;
        frz_cnt_d = frz_cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            StRun: begin
                frz_cnt_d = '0;
                if (mem_busy) state_d = StFreeze;
            end
            StFreeze: begin
                if (!mem_busy) begin
                    state_d   = StRun;
                    frz_cnt_d = '0;
                end else if (frz_cnt_q == FreezeLimit) begin
                    state_d   = StTimeout;
                    timeout_d = 1'b1;
                end else begin
                    frz_cnt_d = frz_cnt_q + 8'd1;
                end
            end
            StTimeout: begin
                if (!mem_busy) begin
                    state_d   = StRun;
                    frz_cnt_d = '0;
                end
            end
            default: begin
                state_d   = StRun;
                frz_cnt_d = '0;
            end
        endcase
        if (clear_counters) timeout_d = 1'b0;
    end

    // FSM, freeze counter and timeout registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StRun;
            frz_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frz_cnt_q <= frz_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    sat_counter16 u_stall_cnt (
        .clk_i   (clk),
        .rst_i   (reset),
        .en_i    (stall_en),
        .clr_i   (clear_counters),
        .count_o (stall_cycles)
    );

    sat_counter16 u_flush_cnt (
        .clk_i   (clk),
        .rst_i   (reset),
        .en_i    (flush_en),
        .clr_i   (clear_counters),
        .count_o (flush_count)
    );

    assign mem_timeout = timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
// Bench for hazard_ctrl: directed scenarios followed by random traffic, all
// checked against a reference model kept in terms of busy-run length and counts.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction_ID = '0;
    logic [31:0] instruction_EX = '0;
    logic        MemRead_EX = 1'b0;
    logic        BranchEQ_EX = 1'b0;
    logic        BranchNE_EX = 1'b0;
    logic        Jump_EX = 1'b0;
    logic        Zero_EX = 1'b0;
    logic        mem_busy = 1'b0;
    logic        clear_counters = 1'b0;
    logic        PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
    logic        IF_ID_Flush, ID_EX_Bubble, PC_Src_Taken;
    logic [15:0] stall_cycles, flush_count;
    logic        mem_timeout;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    // Reference model: length of the current run of busy edges, and counts
    int m_busy_run = 0;
    int m_stall    = 0;
    int m_flush    = 0;
    bit m_tmo      = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .instruction_ID (instruction_ID),
        .instruction_EX (instruction_EX),
        .MemRead_EX     (MemRead_EX),
        .BranchEQ_EX    (BranchEQ_EX),
        .BranchNE_EX    (BranchNE_EX),
        .Jump_EX        (Jump_EX),
        .Zero_EX        (Zero_EX),
        .mem_busy       (mem_busy),
        .clear_counters (clear_counters),
        .PC_Write       (PC_Write),
        .IF_ID_Write    (IF_ID_Write),
        .ID_EX_Write    (ID_EX_Write),
        .EX_MEM_Write   (EX_MEM_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Bubble   (ID_EX_Bubble),
        .PC_Src_Taken   (PC_Src_Taken),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
        .mem_timeout    (mem_timeout),
        .state          (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Expected FSM state from how many consecutive edges saw mem_busy high
    function automatic logic [31:0] exp_state();
        if (m_busy_run == 0) return 32'd0;
        if (m_busy_run <= 256) return 32'd1;
        return 32'd2;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, " state"}, 32'(state), exp_state());
        chk({tag, " stall"}, 32'(stall_cycles), 32'(m_stall));
        chk({tag, " flush"}, 32'(flush_count), 32'(m_flush));
        chk({tag, " tmo"}, 32'(mem_timeout), 32'(m_tmo));
    endtask

    // One clock: drive at negedge, check outputs, clock, update model, check state
    task automatic step(input string tag, input logic [31:0] iid, input logic [31:0] iex,
                        input logic mr, input logic beq, input logic bne, input logic jmp,
                        input logic z, input logic mb, input logic clr);
        logic [5:0]  op;
        logic [4:0]  rs, rt, rtx;
        logic        tk, ur, lu;
        logic [6:0]  exp_o;
        @(negedge clk);
        instruction_ID = iid;
        instruction_EX = iex;
        MemRead_EX     = mr;
        BranchEQ_EX    = beq;
        BranchNE_EX    = bne;
        Jump_EX        = jmp;
        Zero_EX        = z;
        mem_busy       = mb;
        clear_counters = clr;
        #1;
        op  = iid[31:26];
        rs  = iid[25:21];
        rt  = iid[20:16];
        rtx = iex[20:16];
        tk  = (beq && z) || (bne && !z) || jmp;
        ur  = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43);
        lu  = mr && (rtx != 5'd0) && ((rtx == rs) || (ur && (rtx == rt)));
        // {PC, IF/ID, ID/EX, EX/MEM writes, flush, bubble, pc_src}
        if (mb)      exp_o = 7'b0000000;
        else if (tk) exp_o = 7'b1111111;
        else if (lu) exp_o = 7'b0011010;
        else         exp_o = 7'b1111000;
        chk({tag, " outs"}, 32'({PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                                 IF_ID_Flush, ID_EX_Bubble, PC_Src_Taken}), 32'(exp_o));
        @(posedge clk);
        m_busy_run = mb ? m_busy_run + 1 : 0;
        if (clr) begin
            m_stall = 0;
            m_flush = 0;
            m_tmo   = 1'b0;
        end else begin
            if (mb || (!tk && lu)) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            if (!mb && tk) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
            if (m_busy_run == 257) m_tmo = 1'b1;
        end
        #1;
        check_regs(tag);
    endtask

    task automatic idle_inputs();
        instruction_ID = '0;
        instruction_EX = '0;
        MemRead_EX     = 1'b0;
        BranchEQ_EX    = 1'b0;
        BranchNE_EX    = 1'b0;
        Jump_EX        = 1'b0;
        Zero_EX        = 1'b0;
        mem_busy       = 1'b0;
        clear_counters = 1'b0;
    endtask

    task automatic model_reset();
        m_busy_run = 0;
        m_stall    = 0;
        m_flush    = 0;
        m_tmo      = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        #1;
        model_reset();
        check_regs(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] lw5, add_rs5;
    logic [5:0]  ops [7];

    initial begin
        ops = '{6'd0, 6'd4, 6'd5, 6'd43, 6'd8, 6'd35, 6'd2};
        lw5     = mk(6'd35, 5'd1, 5'd5, 16'h0010);
        add_rs5 = mk(6'd0, 5'd5, 5'd6, 16'h3020);

        // Power-on reset
        #1;
        model_reset();
        check_regs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Load-use on rs, then non-hazards
        step("lu_rs", add_rs5, lw5, 1, 0, 0, 0, 0, 0, 0);
        step("addi_rt", mk(6'd8, 5'd0, 5'd5, 16'h1), lw5, 1, 0, 0, 0, 0, 0, 0);
        step("lw_r0", mk(6'd0, 5'd0, 5'd7, 16'h0), mk(6'd35, 5'd2, 5'd0, 16'h0),
             1, 0, 0, 0, 0, 0, 0);
        step("sw_rt", mk(6'd43, 5'd9, 5'd5, 16'h4), lw5, 1, 0, 0, 0, 0, 0, 0);
        step("beq_rt", mk(6'd4, 5'd9, 5'd5, 16'h4), lw5, 1, 0, 0, 0, 0, 0, 0);

        // Redirects, with and without a concurrent load-use
        step("beq_lu", add_rs5, lw5, 1, 1, 0, 0, 1, 0, 0);
        step("beq_nt", add_rs5, lw5, 1, 1, 0, 0, 0, 0, 0);
        step("bne_t", add_rs5, '0, 0, 0, 1, 0, 0, 0, 0);
        step("bne_nt", add_rs5, '0, 0, 0, 1, 0, 1, 0, 0);
        step("jump", add_rs5, '0, 0, 0, 0, 1, 1, 0, 0);

        // Busy beats everything
        step("busy_tk", add_rs5, lw5, 1, 0, 0, 1, 0, 1, 0);
        step("busy_end", '0, '0, 0, 0, 0, 0, 0, 0, 0);

        // Long freeze into timeout, sticky after release, then clear
        for (int i = 0; i < 300; i++) step("frz300", add_rs5, '0, 0, 0, 0, 0, 0, 1, 0);
        step("rel", '0, '0, 0, 0, 0, 0, 0, 0, 0);
        step("sticky", add_rs5, lw5, 1, 0, 0, 0, 0, 0, 0);
        step("clr", '0, '0, 0, 0, 0, 1, 1, 0, 1);
        step("after_clr", '0, '0, 0, 0, 0, 1, 1, 0, 0);

        // Saturate the stall counter, then clear while still counting
        do_reset("reset2");
        for (int i = 0; i < 65540; i++) step("sat", '0, '0, 0, 0, 0, 0, 0, 1, 0);
        chk("sat stall literal", 32'(stall_cycles), 32'hFFFF);
        step("sat_clr", '0, '0, 0, 0, 0, 0, 0, 1, 1);
        step("sat_rel", '0, '0, 0, 0, 0, 0, 0, 0, 0);

        // Reset asserted between edges in the middle of a freeze
        for (int i = 0; i < 4; i++) step("prefrz", '0, '0, 0, 0, 0, 1, 0, 1, 0);
        chk("prefrz literal", 32'(state), 32'd1);
        @(posedge clk);
        #2;
        idle_inputs();
        reset = 1'b1;
        #1;
        model_reset();
        check_regs("mid_rst");
        @(negedge clk);
        reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] iid, iex;
            logic mb, clr;
            iid = mk(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 16'($urandom));
            iex = mk(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 16'($urandom));
            mb  = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 49) == 0);
            step("rand", iid, iex, 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 5) == 0), 1'($urandom), mb, clr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and one reset: reset is asynchronous and active-high.
REQ-002 Port clk  in  1  rising-edge clock for all state.
REQ-003 Port reset  in  1  asynchronous active-high reset.
REQ-004 Port instruction_ID  in  32  instruction held in IF/ID; rs=[25:21], rt=[20:16], opcode=[31:26].
REQ-005 Port instruction_EX  in  32  instruction held in ID/EX; rt=[20:16].
REQ-006 Port MemRead_EX, BranchEQ_EX, BranchNE_EX, Jump_EX, Zero_EX  in  1 each  EX-stage control bits and ALU zero flag.
REQ-007 Port mem_busy  in  1  data memory not ready; pipeline must freeze.
REQ-008 Port clear_counters  in  1  synchronous clear of both counters and the timeout flag.
REQ-009 Port PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write  out  1 each  stage write enables.
REQ-010 Port IF_ID_Flush, ID_EX_Bubble  out  1 each  zero IF/ID instruction; zero all ID/EX control bits.
REQ-011 Port PC_Src_Taken  out  1  select branch/jump target into PC.
REQ-012 Port stall_cycles, flush_count  out  16 each  saturating performance counters.
REQ-013 Port mem_timeout  out  1  sticky: freeze exceeded 255 cycles.
REQ-014 Port state  out  2  current FSM state encoding.

Function
REQ-015 taken SHALL be (BranchEQ_EX & Zero_EX) | (BranchNE_EX & ~Zero_EX) | Jump_EX.
REQ-016 uses_rt SHALL be 1 when opcode_ID is 0 (R-type), 4 (beq), 5 (bne) or 43 (sw); else 0.
REQ-017 load_use SHALL be MemRead_EX & (rt_EX != 0) & ((rt_EX == rs_ID) | (uses_rt & rt_EX == rt_ID)).
REQ-018 FSM states SHALL be RUN=0, FREEZE=1, TIMEOUT=2; encoding 3 is unused and SHALL return to RUN next edge.
REQ-019 Transitions: RUN->FREEZE when mem_busy=1 at an edge; FREEZE->RUN when mem_busy=0; FREEZE->TIMEOUT when freeze counter reaches 255 with mem_busy=1; TIMEOUT->RUN when mem_busy=0.
REQ-020 Freeze counter: 8-bit, cleared in RUN, +1 per FREEZE cycle; no wrap.
REQ-021 Outputs SHALL be combinational, priority highest first: mem_busy=1 (any state) -> all four write enables 0, Flush/Bubble/PC_Src_Taken 0.
REQ-022 Else taken=1 -> all write enables 1, PC_Src_Taken=1, IF_ID_Flush=1, ID_EX_Bubble=1; load_use ignored.
REQ-023 Else load_use=1 -> PC_Write=0, IF_ID_Write=0, ID_EX_Write=1, ID_EX_Bubble=1, EX_MEM_Write=1.
REQ-024 Else all write enables 1, all other outputs 0.
REQ-025 stall_cycles SHALL +1 at each edge where the REQ-021 or REQ-023 case applies; flush_count SHALL +1 at each edge where the REQ-022 case applies.
REQ-026 Both counters SHALL saturate at 0xFFFF; clear_counters=1 SHALL force 0 at the next edge, overriding increments.
REQ-027 mem_timeout SHALL set on entry to TIMEOUT and hold until clear_counters or reset.

Reset
REQ-028 While reset=1: state=RUN, freeze counter=0, stall_cycles=0, flush_count=0, mem_timeout=0; combinational outputs follow REQ-021..024 from current inputs.
REQ-029 Reset asserted mid-FREEZE SHALL return to RUN immediately, no edge required.

Structure
REQ-030 Package hazard_pkg SHALL hold opcode constants (R-type 0, beq 4, bne 5, sw 43), field bit positions, state encodings and the 255 timeout limit.
REQ-031 One sub-module sat_counter16 (enable, clear, 16-bit saturating) SHALL be instantiated twice.

Verification
REQ-032 instruction_EX=lw rt=5 with MemRead_EX=1; instruction_ID=add rs=5 -> PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; stall_cycles 0->1.
REQ-033 Same load; ID=addi rt=5, rs=0 (uses_rt=0) -> no stall; load rt=0 with ID rs=0 -> no stall.
REQ-034 BranchEQ_EX=1, Zero_EX=1, concurrent load_use -> PC_Src_Taken=1, IF_ID_Flush=1, ID_EX_Bubble=1, flush_count+1, stall_cycles unchanged.
REQ-035 mem_busy held 300 cycles -> all write enables 0; state FREEZE then TIMEOUT after 255; mem_timeout=1 sticky after mem_busy drops; state RUN.
REQ-036 Preload stall_cycles to 0xFFFF via long freeze -> stays 0xFFFF; clear_counters=1 -> 0 next edge.
REQ-037 reset pulsed mid-FREEZE between edges -> state=0 and counters=0 immediately.
